// File: rtl/mem_access_if.sv
// Bus-side bundle of the LC-3 memory access unit: datapath loads, access request,
// MAR/MDR views, SRAM strobes/data, and the FSM state for observation.
interface mem_access_if;
  // Handshake: mem_start (with mem_write) is a request that is taken only on an
  // edge where mem_busy is low. Requests made while mem_busy is high are dropped,
  // not queued. Every accepted request ends with exactly one mem_rdy pulse,
  // which is held for one cycle.
  logic [15:0] busIn;
  logic        LD_MAR;
  logic        LD_MDR;
  logic        mem_start;
  logic        mem_write;
  logic [15:0] MAR_out;
  logic [15:0] MDR_out;
  logic        mem_busy;
  logic        mem_rdy;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic [1:0]  state_dbg;

  modport slave (
    input  busIn, LD_MAR, LD_MDR, mem_start, mem_write, mem_rdata,
    output MAR_out, MDR_out, mem_busy, mem_rdy, mem_addr, mem_wdata,
    output mem_ce_n, mem_oe_n, mem_we_n, state_dbg
  );

  modport master (
    output busIn, LD_MAR, LD_MDR, mem_start, mem_write, mem_rdata,
    input  MAR_out, MDR_out, mem_busy, mem_rdy, mem_addr, mem_wdata,
    input  mem_ce_n, mem_oe_n, mem_we_n, state_dbg
  );
endinterface

// File: rtl/mem_access_unit.sv
// LC-3 MAR/MDR holder and asynchronous-SRAM access sequencer with a fixed
// number of wait states and a one-cycle completion pulse.
module mem_access_unit #(
  parameter int WAIT_STATES = 2
) (
  input  logic          Clk,
  input  logic          Reset_n,
  mem_access_if.slave   bus
);

  localparam int CW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [15:0]   mar_q, mar_d;
  logic [15:0]   mdr_q, mdr_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    case (state_q)
      IDLE: begin
        if (bus.LD_MAR) mar_d = bus.busIn;
        if (bus.LD_MDR) mdr_d = bus.busIn;
        if (bus.mem_start) begin
          wr_d    = bus.mem_write;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Read data is captured on the edge that closes the access window.
        if (cnt_q == CNT_LAST) begin
          if (!wr_q) mdr_d = bus.mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode from registered state only, so input glitches never reach the SRAM.
  assign bus.mem_ce_n  = (state_q != ACCESS);
  assign bus.mem_oe_n  = !((state_q == ACCESS) && !wr_q);
  assign bus.mem_we_n  = !((state_q == ACCESS) && wr_q);
  assign bus.mem_rdy   = (state_q == DONE);
  assign bus.mem_busy  = (state_q != IDLE);
  assign bus.MAR_out   = mar_q;
  assign bus.MDR_out   = mdr_q;
  assign bus.mem_addr  = mar_q;
  assign bus.mem_wdata = mdr_q;
  assign bus.state_dbg = state_q;

endmodule
